// File: rtl/rv_pkg.sv
// rv_pkg: shared mini-rv widths, reset PC, fetch FSM states and fetch entry type
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic {RUN, FLUSH} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: IMEM request/response, redirect and decode handshake signals of the fetch stage
interface fetch_unit_if;
  import rv_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            take_branch;
  logic            is_jump;
  logic [XLEN-1:0] redirect_target;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, take_branch, is_jump, redirect_target, out_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, take_branch, is_jump, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flash clear
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output logic [AW:0]  count,
  output fetch_entry_t head
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  // pointers and occupancy; clear discards everything including a same-cycle push or pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // entry storage, zeroed on reset so the head reads as zero
  always_ff @(posedge clk or posedge rst)
    if (rst) mem <= '{default: '0};
    else if (push && !clear) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: mini-rv fetch stage; PC, in-order IMEM fetch, instruction buffer, redirect flush.
// Optional FETCH_PERF_EN adds perf_redirects / perf_stalls counters.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_redirects,
  output logic [31:0]        perf_stalls,
`endif
  fetch_unit_if.master       bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop, drop_next, buf_count, pcq_count;
  fetch_entry_t    buf_head, pcq_head, buf_in, pcq_in;
  logic            redirect, accept, rsp_take, pop;
  assign redirect = bus.take_branch | bus.is_jump;
  assign bus.imem_req_valid = ~rst & (state == RUN) & ~redirect & ((pcq_count + buf_count) < CW'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = buf_count != '0;
  assign bus.out_pc         = buf_head.pc;
  assign bus.out_instr      = buf_head.instr;
  assign accept   = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_take = bus.imem_rsp_valid & (state == RUN) & ~redirect;
  assign pop      = bus.out_valid & bus.out_ready & ~redirect;
  // the PC queue occupancy is the in-flight count in RUN; a redirect turns it into the stale-drop count
  always_comb begin
    drop_next  = (state == FLUSH) ? drop - CW'(bus.imem_rsp_valid)
               : redirect ? pcq_count - CW'(bus.imem_rsp_valid) : '0;
    state_next = ((state == FLUSH) || redirect) && (drop_next != '0) ? FLUSH : RUN;
    pcq_in     = '{pc: pc, instr: '0};
    buf_in     = pcq_head;
    buf_in.instr = bus.imem_rsp_data;
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_next;
  // PC and stale-response counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc   <= RESET_PC;
      drop <= '0;
    end else begin
      pc   <= redirect ? align_word(bus.redirect_target) : accept ? pc + XLEN'(4) : pc;
      drop <= drop_next;
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk(clk), .rst(rst), .push(rsp_take), .pop(pop), .clear(redirect),
    .din(buf_in), .count(buf_count), .head(buf_head)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk(clk), .rst(rst), .push(accept), .pop(rsp_take), .clear(redirect),
    .din(pcq_in), .count(pcq_count), .head(pcq_head)
  );
`ifdef FETCH_PERF_EN
  // event counters; wrap naturally and keep running during FLUSH
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_redirects <= '0;
      perf_stalls    <= '0;
    end else begin
      perf_redirects <= perf_redirects + 32'(redirect);
      perf_stalls    <= perf_stalls + 32'(bus.out_ready & ~bus.out_valid);
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized IMEM model plus PC-stream reference checking the fetch stage
module tb_fetch_unit;
  import rv_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  fetch_unit_if bus();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects, perf_stalls;
`endif
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
`ifdef FETCH_PERF_EN
    .perf_redirects(perf_redirects),
    .perf_stalls(perf_stalls),
`endif
    .bus(bus.master)
  );
  int vectors = 0, errors = 0;
  int cyc = 0, lat_min = 1, lat_max = 1, rdy_mode = 0;
  int pops = 0, accepts = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_pc = 32'h0;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction
  // IMEM acceptance bookkeeping and the reference model of the decode stream
  always @(posedge clk or posedge rst)
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      exp_pc = 32'h0;
    end else begin
      cyc++;
      if (bus.imem_rsp_valid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend_addr.push_back(bus.imem_req_addr);
        pend_due.push_back(cyc + $urandom_range(lat_max, lat_min) - 1);
        acc_log.push_back(bus.imem_req_addr);
        accepts++;
      end
      if (bus.take_branch || bus.is_jump) exp_pc = bus.redirect_target & ~32'h3;
      else if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (bus.out_pc !== exp_pc || bus.out_instr !== instr_of(exp_pc)) begin
          errors++;
          $display("FAIL stream: got pc=%h instr=%h, expected pc=%h instr=%h", bus.out_pc, bus.out_instr, exp_pc, instr_of(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        pops++;
      end
    end
  // IMEM response and ready drive, in order, latency >= 1
  always @(negedge clk) begin
    bus.imem_req_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom_range(1, 0));
    bus.imem_rsp_valid = !rst && pend_due.size() > 0 && pend_due[0] <= cyc;
    bus.imem_rsp_data  = pend_addr.size() > 0 ? instr_of(pend_addr[0]) : 32'h0;
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    vectors++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    vectors++;
    if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out: got %h/%h expected 0/0", bus.out_pc, bus.out_instr); end
    rst = 0;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got %b/%h expected 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
  endtask
  task automatic test_fill();
    int p0 = pops;
    repeat (30) tick();
    vectors++;
    if (pops - p0 < 15) begin errors++; $display("FAIL fill_throughput: got %0d pops expected >= 15", pops - p0); end
  endtask
  task automatic test_stall();
    logic [31:0] hpc = 0, hin = 0;
    bit held = 0;
    bus.out_ready = 0;
    repeat (5) begin
      tick();
      vectors++;
      if (accepts - pops > 2) begin errors++; $display("FAIL stall_reserve: got %0d in flight+buffered expected <= 2", accepts - pops); end
      if (bus.out_valid && held) begin
        vectors++;
        if (bus.out_pc !== hpc || bus.out_instr !== hin) begin errors++; $display("FAIL stall_hold: got %h/%h expected %h/%h", bus.out_pc, bus.out_instr, hpc, hin); end
      end
      if (bus.out_valid && !held) begin hpc = bus.out_pc; hin = bus.out_instr; held = 1; end
    end
    vectors++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", bus.out_valid); end
    bus.out_ready = 1;
    repeat (10) tick();
  endtask
  task automatic test_branch();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend_addr.size() != 2; i++) tick();
    vectors++;
    if (pend_addr.size() != 2) begin errors++; $display("FAIL branch_inflight: got %0d expected 2", pend_addr.size()); end
    bus.take_branch = 1; bus.redirect_target = 32'h100;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL branch_req_same_cycle: got %b expected 0", bus.imem_req_valid); end
    tick();
    bus.take_branch = 0;
    #1;
    for (int i = 0; i < 10 && pend_addr.size() > 0; i++) begin
      vectors++;
      if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_no_req: got %b expected 0", bus.imem_req_valid); end
      tick();
    end
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin errors++; $display("FAIL branch_restart: got %b/%h expected 1/00000100", bus.imem_req_valid, bus.imem_req_addr); end
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin errors++; $display("FAIL branch_out_pc: got %b/%h expected 1/00000100", bus.out_valid, bus.out_pc); end
    lat_min = 1; lat_max = 1;
    repeat (10) tick();
  endtask
  task automatic test_jump();
    rdy_mode = 1;
    repeat (5) tick();
    vectors++;
    if (pend_addr.size() != 0) begin errors++; $display("FAIL jump_idle: got %0d in flight expected 0", pend_addr.size()); end
    bus.is_jump = 1; bus.redirect_target = 32'h203;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL jump_req_same_cycle: got %b expected 0", bus.imem_req_valid); end
    tick();
    bus.is_jump = 0;
    rdy_mode = 0;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin errors++; $display("FAIL jump_next_req: got %b/%h expected 1/00000200", bus.imem_req_valid, bus.imem_req_addr); end
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    vectors++;
    if (bus.out_pc !== 32'h200) begin errors++; $display("FAIL jump_out_pc: got %h expected 00000200", bus.out_pc); end
    repeat (8) tick();
  endtask
  task automatic test_collide();
    for (int i = 0; i < 20 && !(bus.imem_rsp_valid && bus.out_valid); i++) tick();
    vectors++;
    if (!(bus.imem_rsp_valid && bus.out_valid)) begin errors++; $display("FAIL collide_setup: got rsp=%b out=%b expected 1/1", bus.imem_rsp_valid, bus.out_valid); end
    bus.take_branch = 1; bus.redirect_target = 32'h40;
    tick();
    bus.take_branch = 0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL collide_out_valid: got %b expected 0", bus.out_valid); end
    bus.is_jump = 1; bus.redirect_target = 32'h80;
    tick();
    bus.is_jump = 0;
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h80 || bus.out_instr !== instr_of(32'h80)) begin errors++; $display("FAIL b2b_out: got %b/%h/%h expected 1/00000080/%h", bus.out_valid, bus.out_pc, bus.out_instr, instr_of(32'h80)); end
    repeat (8) tick();
  endtask
  task automatic test_wrap_and_rst();
    int p0;
    bus.is_jump = 1; bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.is_jump = 0;
    acc_log.delete();
    repeat (6) tick();
    vectors++;
    if (acc_log.size() < 2) begin errors++; $display("FAIL wrap_reqs: got %0d expected >= 2", acc_log.size()); end
    else if (acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h,%h expected fffffffc,00000000", acc_log[0], acc_log[1]); end
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend_addr.size() != 2; i++) tick();
    bus.take_branch = 1; bus.redirect_target = 32'h300;
    tick();
    bus.take_branch = 0;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b0 || pend_addr.size() == 0) begin errors++; $display("FAIL rst_flush_setup: got req=%b pend=%0d expected 0/>0", bus.imem_req_valid, pend_addr.size()); end
    rst = 1;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0) begin errors++; $display("FAIL rst_mid_flush: got %b/%b/%h/%h expected 0/0/0/0", bus.imem_req_valid, bus.out_valid, bus.out_pc, bus.out_instr); end
    lat_min = 1; lat_max = 1;
    repeat (2) tick();
    rst = 0;
    #1;
    vectors++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_restart: got %b/%h expected 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
    p0 = pops;
    repeat (15) tick();
    vectors++;
    if (pops - p0 < 5) begin errors++; $display("FAIL rst_resume: got %0d pops expected >= 5", pops - p0); end
  endtask
  task automatic test_random();
    int p0 = pops;
    rdy_mode = 2; lat_min = 1; lat_max = 4;
    repeat (500) begin
      bus.out_ready = 1'($urandom_range(1, 0));
      bus.take_branch = $urandom_range(99, 0) < 3;
      bus.is_jump = !bus.take_branch && $urandom_range(99, 0) < 2;
      bus.redirect_target = $urandom();
      tick();
      vectors++;
      if (pend_addr.size() > 2) begin errors++; $display("FAIL rand_inflight: got %0d expected <= 2", pend_addr.size()); end
    end
    bus.take_branch = 0; bus.is_jump = 0; bus.out_ready = 1;
    rdy_mode = 0;
    repeat (20) tick();
    vectors++;
    if (pops - p0 < 50) begin errors++; $display("FAIL rand_progress: got %0d pops expected >= 50", pops - p0); end
  endtask
  initial begin
    bus.take_branch = 0;
    bus.is_jump = 0;
    bus.redirect_target = 0;
    bus.out_ready = 1;
    test_reset();
    test_fill();
    test_stall();
    test_branch();
    test_jump();
    test_collide();
    test_wrap_and_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
